// File: rtl/cgra_pkg.sv
// cgra_pkg: shared CGRA types and defaults for the functional-unit input stage.
package cgra_pkg;
    localparam int NUM_DIRS = 4;
    localparam int DATA_WIDTH_DEFAULT = 32;
    typedef enum logic [1:0] {DIR_W, DIR_S, DIR_E, DIR_N} dir_e;
    typedef enum logic {MODE_JOIN, MODE_MERGE} fire_mode_e;
endpackage

// File: rtl/eb_fifo.sv
// eb_fifo: small elastic buffer with a registered occupancy count and reset-cleared storage.
module eb_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    assign head = mem[rd_ptr];
    assign empty = count == '0;
    assign full = count == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/fu_input_join_merge.sv
// fu_input_join_merge: buffers the four neighbour channels and fires operands to the FU
// with join (all masked inputs present) or merge (cin picks A or B) semantics.
module fu_input_join_merge
    import cgra_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int NUM_IN = NUM_DIRS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   mux_a_sel_i,
    input  logic [1:0]                   mux_b_sel_i,
    input  logic [1:0]                   mux_c_sel_i,
    input  logic [NUM_IN-1:0]            join_mask_i,
    input  logic                         merge_en_i,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data_i,
    input  logic [NUM_IN-1:0]            in_v_i,
    output logic [NUM_IN-1:0]            in_r_o,
    output logic [DATA_WIDTH-1:0]        out_a_o,
    output logic [DATA_WIDTH-1:0]        out_b_o,
    output logic                         out_cin_o,
    output logic                         out_v_o,
    input  logic                         out_r_i
);
    logic [DATA_WIDTH-1:0] head [NUM_IN];
    logic [NUM_IN-1:0] empty, full, push, pop;
    logic join_v, merge_v, fire;
    fire_mode_e mode;
    dir_e sel;
    for (genvar g = 0; g < NUM_IN; g++) begin : g_fifo
        eb_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clk_i),
            .rst(rst_i),
            .push(push[g]),
            .pop(pop[g]),
            .data(in_data_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .head(head[g]),
            .empty(empty[g]),
            .full(full[g])
        );
    end
    assign mode = fire_mode_e'(merge_en_i);
    // Readiness depends only on registered occupancy, never on out_r_i.
    assign in_r_o = rst_i ? '0 : join_mask_i & ~full;
    assign push = in_v_i & in_r_o;
    assign out_cin_o = !rst_i && !empty[mux_c_sel_i] && head[mux_c_sel_i][0];
    assign sel = out_cin_o ? dir_e'(mux_b_sel_i) : dir_e'(mux_a_sel_i);
    assign join_v = |join_mask_i && &(~join_mask_i | ~empty);
    assign merge_v = !empty[mux_c_sel_i] && !empty[sel];
    assign out_v_o = !rst_i && (mode == MODE_MERGE ? merge_v : join_v);
    assign fire = out_v_o & out_r_i;
    // A one-hot OR collapses shared selections, so an input never pops twice.
    assign pop = !fire ? '0 :
                 mode == MODE_MERGE ? (NUM_IN'(1) << mux_c_sel_i) | (NUM_IN'(1) << sel) :
                 join_mask_i;
    assign out_a_o = head[mode == MODE_MERGE ? sel : mux_a_sel_i];
    assign out_b_o = head[mux_b_sel_i];
endmodule

// File: tb/tb_fu_input_join_merge.sv
// tb_fu_input_join_merge: directed and randomized checks against a queue-based token model.
module tb_fu_input_join_merge;
    localparam int DEPTH = 2;
    logic clk = 0;
    logic rst;
    logic [1:0] sa, sb, sc;
    logic [3:0] mask, vin, rdy;
    logic merge, cin, ov, ordy;
    logic [127:0] din;
    logic [31:0] oa, ob;
    int checks = 0, failures = 0, dfires = 0;
    logic [31:0] q[4][$];
    logic [31:0] got_a[$], got_b[$];
    logic got_c[$];
    logic exp_v, exp_cin, a_known, b_known;
    logic [3:0] exp_r;
    logic [1:0] exp_sel;
    logic [31:0] exp_a, exp_b;

    fu_input_join_merge #(.DATA_WIDTH(32), .NUM_IN(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .mux_a_sel_i(sa), .mux_b_sel_i(sb), .mux_c_sel_i(sc),
        .join_mask_i(mask), .merge_en_i(merge), .in_data_i(din), .in_v_i(vin), .in_r_o(rdy),
        .out_a_o(oa), .out_b_o(ob), .out_cin_o(cin), .out_v_o(ov), .out_r_i(ordy)
    );

    always #5 clk = ~clk;

    task automatic set_in(input int i, input logic [31:0] v);
        din[i*32 +: 32] = v;
    endtask

    // Expected outputs from the token queues and the firing rules.
    task automatic predict();
        logic [31:0] t;
        int src;
        for (int i = 0; i < 4; i++) exp_r[i] = mask[i] && (q[i].size() < DEPTH);
        exp_cin = 0;
        if (q[sc].size() > 0) begin
            t = q[sc][0];
            exp_cin = t[0];
        end
        exp_sel = exp_cin ? sb : sa;
        if (merge) exp_v = q[sc].size() > 0 && q[exp_sel].size() > 0;
        else begin
            exp_v = mask != 0;
            for (int i = 0; i < 4; i++) if (mask[i] && q[i].size() == 0) exp_v = 0;
        end
        src = merge ? int'(exp_sel) : int'(sa);
        a_known = q[src].size() > 0;
        b_known = q[sb].size() > 0;
        exp_a = '0;
        exp_b = '0;
        if (a_known) exp_a = q[src][0];
        if (b_known) exp_b = q[sb][0];
    endtask

    task automatic tick();
        logic [3:0] pu, po;
        logic [31:0] pd[4];
        logic f;
        predict();
        pu = vin & exp_r;
        f = exp_v && ordy && !rst;
        po = merge ? ((4'b1 << sc) | (4'b1 << exp_sel)) : mask;
        for (int i = 0; i < 4; i++) pd[i] = din[i*32 +: 32];
        if (ov && ordy) begin
            dfires++;
            got_a.push_back(oa);
            got_b.push_back(ob);
            got_c.push_back(cin);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 4; i++) q[i].delete();
        end else begin
            if (f) for (int i = 0; i < 4; i++) if (po[i]) void'(q[i].pop_front());
            for (int i = 0; i < 4; i++) if (pu[i]) q[i].push_back(pd[i]);
        end
    endtask

    task automatic clr();
        got_a.delete();
        got_b.delete();
        got_c.delete();
        dfires = 0;
    endtask

    task automatic configure(input logic [3:0] m, input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] c, input logic mg);
        mask = m; sa = a; sb = b; sc = c; merge = mg;
        rst = 1; vin = 0; ordy = 0;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 4; i++) q[i].delete();
        clr();
    endtask

    task automatic test_reset();
        mask = 4'hF; sa = 0; sb = 1; sc = 2; merge = 0;
        vin = 4'hF; din = {$urandom, $urandom, $urandom, $urandom}; ordy = 1; rst = 1;
        @(posedge clk);
        #1;
        checks++; if (rdy !== 4'h0) begin failures++; $display("FAIL reset_rdy got=%b exp=0000", rdy); end
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_v got=%b exp=0", ov); end
        checks++; if (cin !== 1'b0) begin failures++; $display("FAIL reset_cin got=%b exp=0", cin); end
        checks++; if (oa !== 32'h0) begin failures++; $display("FAIL reset_a got=%h exp=0", oa); end
        checks++; if (ob !== 32'h0) begin failures++; $display("FAIL reset_b got=%h exp=0", ob); end
        rst = 0; vin = 0; ordy = 0;
        for (int i = 0; i < 4; i++) q[i].delete();
        #1;
        checks++; if (rdy !== 4'hF) begin failures++; $display("FAIL release_rdy got=%b exp=1111", rdy); end
    endtask

    task automatic test_join_basic();
        configure(4'b0011, 0, 1, 0, 0);
        ordy = 1;
        for (int t = 0; t < 6; t++) begin
            vin = 0;
            if (t == 0) begin vin[0] = 1; set_in(0, 5); end
            if (t == 3) begin vin[1] = 1; set_in(1, 7); end
            #1;
            predict();
            checks++; if (ov !== exp_v) begin failures++; $display("FAIL join_v t=%0d got=%b exp=%b", t, ov, exp_v); end
            checks++; if (rdy !== exp_r) begin failures++; $display("FAIL join_rdy t=%0d got=%b exp=%b", t, rdy, exp_r); end
            if (t == 4) begin
                checks++;
                if (ov !== 1'b1 || oa !== 32'd5 || ob !== 32'd7) begin
                    failures++; $display("FAIL join_fire v=%b a=%0d b=%0d exp v=1 a=5 b=7", ov, oa, ob);
                end
            end
            if (t == 5) begin
                checks++; if (ov !== 1'b0) begin failures++; $display("FAIL join_after got=%b exp=0", ov); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        configure(4'b0001, 0, 0, 0, 0);
        for (int t = 0; t < 14; t++) begin
            ordy = t >= 6;
            vin = {3'b0, sent < 3};
            set_in(0, 32'(sent + 1));
            #1;
            predict();
            checks++; if (rdy !== exp_r) begin failures++; $display("FAIL bp_rdy t=%0d got=%b exp=%b", t, rdy, exp_r); end
            checks++; if (ov !== exp_v) begin failures++; $display("FAIL bp_v t=%0d got=%b exp=%b", t, ov, exp_v); end
            if (t == 2) begin
                checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", rdy[0]); end
            end
            if (exp_v && a_known) begin
                checks++; if (oa !== exp_a) begin failures++; $display("FAIL bp_a t=%0d got=%0d exp=%0d", t, oa, exp_a); end
            end
            if (vin[0] && exp_r[0]) sent++;
            tick();
        end
        checks++;
        if (got_a.size() != 3 || got_a[0] !== 32'd1 || got_a[1] !== 32'd2 || got_a[2] !== 32'd3) begin
            failures++; $display("FAIL bp_order count=%0d exp=3 tokens 1,2,3", got_a.size());
        end
    endtask

    task automatic test_throughput();
        logic [31:0] tw[100], ts[100];
        int iw = 0, is = 0, bad = 0;
        for (int i = 0; i < 100; i++) begin tw[i] = $urandom; ts[i] = $urandom; end
        configure(4'b0011, 0, 1, 0, 0);
        ordy = 1;
        for (int t = 0; t < 101; t++) begin
            vin = {2'b0, is < 100, iw < 100};
            if (iw < 100) set_in(0, tw[iw]);
            if (is < 100) set_in(1, ts[is]);
            #1;
            predict();
            checks++; if (ov !== exp_v) begin failures++; $display("FAIL tp_v t=%0d got=%b exp=%b", t, ov, exp_v); end
            checks++; if (rdy !== exp_r) begin failures++; $display("FAIL tp_rdy t=%0d got=%b exp=%b", t, rdy, exp_r); end
            if (vin[0] && exp_r[0]) iw++;
            if (vin[1] && exp_r[1]) is++;
            tick();
        end
        checks++; if (dfires !== 100) begin failures++; $display("FAIL tp_fires got=%0d exp=100", dfires); end
        for (int i = 0; i < got_a.size() && i < 100; i++) if (got_a[i] !== tw[i] || got_b[i] !== ts[i]) bad++;
        checks++; if (bad != 0 || got_a.size() != 100) begin failures++; $display("FAIL tp_pairs bad=%0d got=%0d exp=100", bad, got_a.size()); end
    endtask

    task automatic test_merge();
        configure(4'b1101, 2, 3, 0, 1);
        ordy = 1;
        for (int t = 0; t < 5; t++) begin
            vin = 0;
            if (t == 0) begin vin = 4'b1101; set_in(0, 0); set_in(2, 10); set_in(3, 20); end
            if (t == 1) begin vin[0] = 1; set_in(0, 1); end
            #1;
            predict();
            checks++; if (ov !== exp_v) begin failures++; $display("FAIL mg_v t=%0d got=%b exp=%b", t, ov, exp_v); end
            checks++; if (cin !== exp_cin) begin failures++; $display("FAIL mg_cin t=%0d got=%b exp=%b", t, cin, exp_cin); end
            checks++; if (rdy !== exp_r) begin failures++; $display("FAIL mg_rdy t=%0d got=%b exp=%b", t, rdy, exp_r); end
            tick();
        end
        checks++;
        if (got_a.size() != 2 || got_a[0] !== 32'd10 || got_c[0] !== 1'b0 || got_a[1] !== 32'd20 || got_c[1] !== 1'b1) begin
            failures++; $display("FAIL mg_seq count=%0d exp=2 fires (10,cin0) then (20,cin1)", got_a.size());
        end
    endtask

    task automatic test_merge_wait();
        configure(4'b1101, 2, 3, 0, 1);
        ordy = 1;
        for (int t = 0; t < 9; t++) begin
            vin = 0;
            if (t == 0) begin vin = 4'b0101; set_in(0, 1); set_in(2, 10); end
            if (t == 4) begin vin[3] = 1; set_in(3, 20); end
            if (t == 6) begin vin[0] = 1; set_in(0, 0); end
            #1;
            predict();
            checks++; if (ov !== exp_v) begin failures++; $display("FAIL mw_v t=%0d got=%b exp=%b", t, ov, exp_v); end
            if (t == 2) begin
                checks++; if (ov !== 1'b0) begin failures++; $display("FAIL mw_wait got=%b exp=0", ov); end
            end
            if (exp_v) begin
                checks++; if (oa !== exp_a) begin failures++; $display("FAIL mw_a t=%0d got=%0d exp=%0d", t, oa, exp_a); end
            end
            tick();
        end
        checks++;
        if (got_a.size() != 2 || got_a[0] !== 32'd20 || got_a[1] !== 32'd10) begin
            failures++; $display("FAIL mw_seq count=%0d exp=2 fires 20 then 10", got_a.size());
        end
    endtask

    task automatic test_reset_mid();
        configure(4'b0011, 0, 1, 0, 0);
        for (int t = 0; t < 2; t++) begin
            vin = 4'b0001; set_in(0, 32'(t + 40));
            tick();
        end
        rst = 1; vin = 4'b0011; ordy = 1;
        #1;
        checks++; if (rdy !== 4'b0000) begin failures++; $display("FAIL rm_rdy got=%b exp=0000", rdy); end
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL rm_v got=%b exp=0", ov); end
        tick();
        rst = 0; vin = 4'b0010; set_in(1, 9);
        #1;
        checks++; if (rdy !== 4'b0011) begin failures++; $display("FAIL rm_release got=%b exp=0011", rdy); end
        checks++; if (ov !== 1'b0 || dfires !== 0) begin failures++; $display("FAIL rm_nofire v=%b fires=%0d exp 0", ov, dfires); end
        tick();
        vin = 0;
        #1;
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL rm_flushed got=%b exp=0", ov); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            configure(4'($urandom) | (4'b1 << (k % 4)), 2'($urandom), 2'($urandom), 2'($urandom), 1'(k % 2));
            mask = mask | (4'b1 << sa) | (4'b1 << sb) | (merge ? (4'b1 << sc) : 4'b0);
            configure(mask, sa, sb, sc, merge);
            for (int t = 0; t < 150; t++) begin
                vin = 4'($urandom);
                din = {$urandom, $urandom, $urandom, $urandom};
                ordy = $urandom_range(0, 3) != 0;
                #1;
                predict();
                checks++; if (ov !== exp_v) begin failures++; $display("FAIL rnd_v k=%0d t=%0d got=%b exp=%b", k, t, ov, exp_v); end
                checks++; if (rdy !== exp_r) begin failures++; $display("FAIL rnd_rdy k=%0d t=%0d got=%b exp=%b", k, t, rdy, exp_r); end
                checks++; if (cin !== exp_cin) begin failures++; $display("FAIL rnd_cin k=%0d t=%0d got=%b exp=%b", k, t, cin, exp_cin); end
                if (exp_v && a_known) begin
                    checks++; if (oa !== exp_a) begin failures++; $display("FAIL rnd_a k=%0d t=%0d got=%h exp=%h", k, t, oa, exp_a); end
                end
                if (exp_v && b_known) begin
                    checks++; if (ob !== exp_b) begin failures++; $display("FAIL rnd_b k=%0d t=%0d got=%h exp=%h", k, t, ob, exp_b); end
                end
                tick();
            end
        end
    endtask

    initial begin
        rst = 1; vin = 0; ordy = 0; din = '0; mask = 0; sa = 0; sb = 0; sc = 0; merge = 0;
        test_reset();
        test_join_basic();
        test_backpressure();
        test_throughput();
        test_merge();
        test_merge_wait();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
